// File: rtl/am_handler_pkg.sv
// am_handler_pkg: header field positions and dispatcher FSM states shared by the GAScore handler dispatch path
package am_handler_pkg;
   localparam int HDR_DEST_HI    = 39;
   localparam int HDR_DEST_LO    = 24;
   localparam int HDR_HANDLER_HI = 59;
   localparam int HDR_HANDLER_LO = 56;
   typedef enum logic [1:0] {HEADER, FWD, EMPTY, DROP} state_t;
endpackage

// File: rtl/am_out_stage.sv
// am_out_stage: single-entry registered output stage with one-hot per-port valid decode
module am_out_stage
   import am_handler_pkg::*;
#(
   parameter int NUM_KERNELS  = 2,
   parameter int DATA_WIDTH   = 64,
   parameter int KERNEL_WIDTH = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [DATA_WIDTH-1:0]   ld_data,
   input  logic                    ld_last,
   input  logic [3:0]              ld_handler,
   input  logic [KERNEL_WIDTH-1:0] ld_sel,
   input  logic [NUM_KERNELS-1:0]  m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tlast,
   output logic [3:0]              m_axis_handler,
   output logic [NUM_KERNELS-1:0]  m_axis_tvalid,
   output logic                    load_ok,
   output logic                    pop
);
   localparam int PW = 1 << KERNEL_WIDTH;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    last_q, last_d, valid_q, valid_d;
   logic [3:0]              handler_q, handler_d;
   logic [KERNEL_WIDTH-1:0] sel_q, sel_d;
   logic [PW-1:0]           rdy_ext;
   assign rdy_ext        = PW'(m_axis_tready);
   assign pop            = valid_q & rdy_ext[sel_q];
   assign load_ok        = !valid_q | rdy_ext[sel_q];
   assign m_axis_tdata   = data_q;
   assign m_axis_tlast   = last_q;
   assign m_axis_handler = handler_q;
   // Load replaces the held beat; otherwise it stays until its port accepts it
   always_comb begin
      data_d    = load ? ld_data : data_q;
      last_d    = load ? ld_last : last_q;
      handler_d = load ? ld_handler : handler_q;
      sel_d     = load ? ld_sel : sel_q;
      valid_d   = load | (valid_q & !rdy_ext[sel_q]);
   end
   // Stage registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q    <= '0;
         last_q    <= 1'b0;
         handler_q <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         data_q    <= data_d;
         last_q    <= last_d;
         handler_q <= handler_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
      end
   end
   // Only the selected port sees valid
   always_comb begin
      m_axis_tvalid = '0;
      for (int k = 0; k < NUM_KERNELS; k++) m_axis_tvalid[k] = valid_q && (sel_q == KERNEL_WIDTH'(k));
   end
endmodule

// File: rtl/am_handler_dispatch.sv
// am_handler_dispatch: decodes the AM header, routes payload to a kernel port, drops out-of-range packets
module am_handler_dispatch
   import am_handler_pkg::*;
#(
   parameter int NUM_KERNELS = 2,
   parameter int DATA_WIDTH  = 64
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [15:0]            address_offset,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [3:0]             m_axis_handler,
   output logic [NUM_KERNELS-1:0] m_axis_tvalid,
   input  logic [NUM_KERNELS-1:0] m_axis_tready,
   output logic [15:0]            drop_count,
   output logic [15:0]            pkt_count
);
   localparam int KERNEL_WIDTH = (NUM_KERNELS == 1) ? 1 : $clog2(NUM_KERNELS);
   state_t                  state_q, state_d;
   logic [KERNEL_WIDTH-1:0] idx_q, idx_d;
   logic [3:0]              handler_q, handler_d;
   logic [15:0]             drop_q, drop_d, pkt_q, pkt_d, dest_off;
   logic                    in_rdy, load, ld_last, load_ok, pop, in_range;
   logic [DATA_WIDTH-1:0]   ld_data;
   assign dest_off      = s_axis_tdata[HDR_DEST_HI:HDR_DEST_LO] - address_offset;
   assign in_range      = dest_off < 16'(NUM_KERNELS);
   assign s_axis_tready = in_rdy & reset_n;
   assign drop_count    = drop_q;
   assign pkt_count     = pkt_q;
   // Packet FSM: header decode, payload forwarding, synthesised tail, discard
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      handler_d = handler_q;
      drop_d    = drop_q;
      in_rdy    = 1'b0;
      load      = 1'b0;
      ld_data   = s_axis_tdata;
      ld_last   = s_axis_tlast;
      case (state_q)
         HEADER: begin
            in_rdy = 1'b1;
            if (s_axis_tvalid) begin
               handler_d = s_axis_tdata[HDR_HANDLER_HI:HDR_HANDLER_LO];
               idx_d     = dest_off[KERNEL_WIDTH-1:0];
               if (!in_range) begin
                  drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                  state_d = s_axis_tlast ? HEADER : DROP;
               end else begin
                  state_d = s_axis_tlast ? EMPTY : FWD;
               end
            end
         end
         FWD: begin
            in_rdy = load_ok;
            load   = s_axis_tvalid & load_ok;
            if (load && s_axis_tlast) state_d = HEADER;
         end
         EMPTY: begin
            load    = load_ok;
            ld_data = '0;
            ld_last = 1'b1;
            if (load_ok) state_d = HEADER;
         end
         default: begin
            in_rdy = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_d = HEADER;
         end
      endcase
      pkt_d = (pop && m_axis_tlast) ? pkt_q + 16'd1 : pkt_q;
   end
   // FSM, latched header fields and counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= HEADER;
         idx_q     <= '0;
         handler_q <= '0;
         drop_q    <= '0;
         pkt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         handler_q <= handler_d;
         drop_q    <= drop_d;
         pkt_q     <= pkt_d;
      end
   end
   am_out_stage #(
      .NUM_KERNELS (NUM_KERNELS),
      .DATA_WIDTH  (DATA_WIDTH),
      .KERNEL_WIDTH(KERNEL_WIDTH)
   ) u_out (
      .clock         (clock),
      .reset_n       (reset_n),
      .load          (load),
      .ld_data       (ld_data),
      .ld_last       (ld_last),
      .ld_handler    (handler_q),
      .ld_sel        (idx_q),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_handler(m_axis_handler),
      .m_axis_tvalid (m_axis_tvalid),
      .load_ok       (load_ok),
      .pop           (pop)
   );
endmodule
